// File: rtl/serial_pkg.sv
// +--------------------------------------------------------------------+
// | serial_pkg: shared types and helpers for the serial adder front end |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package serial_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int w);
    return ($clog2(w) > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_word_shifter.sv
// +--------------------------------------------------------------------+
// | serial_word_shifter: two-row LSB-first shift register + bit counter |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module serial_word_shifter
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [1:0][WIDTH-1:0] data_i,
  output logic [1:0]            bit0_o,
  output logic                  at_last_o
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [1:0][WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  assign at_last_o = (cnt_q == LAST_CNT);
  assign bit0_o[0] = sh_q[0][0];
  assign bit0_o[1] = sh_q[1][0];

  // Load wins over shift so a reload on the final beat starts a fresh word.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sh_d  = data_i;
      cnt_d = '0;
    end else if (shift_i) begin
      for (int r = 0; r < 2; r++) begin
        sh_d[r] = sh_q[r] >> 1;
      end
      if (!at_last_o) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_operand_feeder.sv
// +--------------------------------------------------------------------+
// | serial_operand_feeder: parallel operand pair in, LSB-first bits out |
// | Option: SERIAL_OPERAND_FEEDER_SKID_EN adds a one-entry skid buffer  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module serial_operand_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             out_en,
  output logic             out_vld,
  output logic             out_a,
  output logic             out_b,
  output logic             out_last
);

  state_e                state_q, state_d;
  logic                  is_shift;
  logic                  accept;
  logic                  commit_last;
  logic                  load;
  logic                  at_last;
  logic [1:0]            bit0;
  logic [1:0][WIDTH-1:0] load_data;

  assign is_shift    = (state_q == SHIFT);
  assign out_vld     = is_shift && out_en;
  assign out_a       = bit0[0];
  assign out_b       = bit0[1];
  assign out_last    = is_shift && at_last;
  assign accept      = in_vld && in_rdy;
  assign commit_last = out_vld && at_last;

`ifdef SERIAL_OPERAND_FEEDER_SKID_EN
  logic                  buf_vld_q, buf_vld_d;
  logic [1:0][WIDTH-1:0] buf_q, buf_d;
  logic                  direct;
  logic                  reload;

  assign in_rdy    = !is_shift || !buf_vld_q;
  // A pair goes straight to the shifter whenever the shifter is free at the edge.
  assign direct    = accept && (!is_shift || (commit_last && !buf_vld_q));
  assign reload    = commit_last && buf_vld_q;
  assign load      = direct || reload;
  assign load_data = reload ? buf_q : {in_b, in_a};

  always_comb begin
    buf_vld_d = buf_vld_q;
    buf_d     = buf_q;
    if (reload) begin
      buf_vld_d = 1'b0;
    end
    if (accept && !direct) begin
      buf_vld_d = 1'b1;
      buf_d     = {in_b, in_a};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_vld_q <= 1'b0;
      buf_q     <= '0;
    end else begin
      buf_vld_q <= buf_vld_d;
      buf_q     <= buf_d;
    end
  end
`else
  assign in_rdy    = !is_shift;
  assign load      = accept;
  assign load_data = {in_b, in_a};
`endif

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = SHIFT;
    end else if (commit_last) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  serial_word_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .shift_i  (out_vld),
    .data_i   (load_data),
    .bit0_o   (bit0),
    .at_last_o(at_last)
  );

endmodule

`default_nettype wire
